// File: rtl/mms_pkg.sv
// -----------------------------------------------------------------------------
// mms_pkg
//   Shared types for the memory-management slice: Sv32 virtual page number,
//   page-table entry, page-table-walker state and request record, plus
//   helpers that classify a PTE.
// -----------------------------------------------------------------------------
package mms_pkg;

    localparam int MMS_PA_WD    = 34;  // Sv32 physical address width
    localparam int MMS_SATP_PPN = 22;  // root-table PPN width from satp

    // Sv32 virtual page number: {vpn[1], vpn[0]}
    typedef struct packed {
        logic [9:0] vpn1;
        logic [9:0] vpn0;
    } vpn_t;

    // Sv32 page-table entry
    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L0_REQ  = 3'd3,
        L0_WAIT = 3'd4,
        DONE    = 3'd5,
        DRAIN   = 3'd6
    } ptw_state_e;

    // Latched walk request: id 0 = ITLB, 1 = DTLB
    typedef struct packed {
        logic id;
        vpn_t vpn;
    } ptw_req_t;

    // Invalid entry, or the reserved write-only encoding
    function automatic logic pte_invalid(pte_t p);
        return !p.v || (!p.r && p.w);
    endfunction

    // Any of R/X set marks a leaf; otherwise the entry points to the next level
    function automatic logic pte_is_leaf(pte_t p);
        return p.r || p.x;
    endfunction

endpackage

// File: rtl/mms_rr_arb2.sv
// -----------------------------------------------------------------------------
// mms_rr_arb2
//   Two-way round-robin arbiter. A lone request is always granted; on a tie
//   the requester that did not win last time is granted. rr_last resets to 1
//   so requester 0 wins the first tie.
// Ports
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request vector
//   en         : grant is actually taken this cycle (updates history)
//   gnt[1:0]   : one-hot (or zero) grant, combinational
// -----------------------------------------------------------------------------
module mms_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_last;  // index of the most recent winner

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] && (!req[1] || rr_last);
        gnt[1] = req[1] && (!req[0] || !rr_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (en && (gnt != 2'b00)) begin
            rr_last <= gnt[1];
        end
    end

endmodule

// File: rtl/mms_ptw.sv
// -----------------------------------------------------------------------------
// mms_ptw
//   Sv32 hardware page-table walker shared by ITLB and DTLB. Arbitrates the
//   two miss requests, walks the 2-level table through a single read port and
//   returns the leaf PTE, whether it is a 4 MiB superpage, or a page fault.
// Ports
//   satp_ppn_i           : root page-table PPN (sampled while in L1_REQ)
//   flush_i              : abort the walk in progress (highest priority)
//   itlb_req_i/vpn_i     : ITLB miss; itlb_ready_o marks acceptance
//   dtlb_req_i/vpn_i     : DTLB miss; dtlb_ready_o marks acceptance
//   mem_req_o/addr_o     : PTE read request, held stable until mem_gnt_i
//   mem_rvalid_i/rdata_i : PTE read return
//   resp_valid_o         : one-cycle result pulse with resp_id/pte/super/fault
//   state_o              : current walker state (debug visibility)
// Handshakes: a TLB request transfers in the cycle where req and ready are
// both high; a memory read transfers in the cycle where mem_req_o and
// mem_gnt_i are both high, and its data arrives later on mem_rvalid_i. Only
// one read is ever outstanding. resp_valid_o carries no back-pressure.
// -----------------------------------------------------------------------------
module mms_ptw
    import mms_pkg::*;
#(
    parameter int PA_WD    = MMS_PA_WD,
    parameter int SATP_PPN = MMS_SATP_PPN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SATP_PPN-1:0] satp_ppn_i,
    input  logic                flush_i,
    input  logic                itlb_req_i,
    input  vpn_t                itlb_vpn_i,
    output logic                itlb_ready_o,
    input  logic                dtlb_req_i,
    input  vpn_t                dtlb_vpn_i,
    output logic                dtlb_ready_o,
    output logic                mem_req_o,
    output logic [PA_WD-1:0]    mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  pte_t                mem_rdata_i,
    output logic                resp_valid_o,
    output logic                resp_id_o,
    output pte_t                resp_pte_o,
    output logic                resp_super_o,
    output logic                resp_fault_o,
    output ptw_state_e          state_o
);

    ptw_state_e  state;
    ptw_req_t    req_q;
    logic [21:0] ppn_q;       // next-level table PPN from an L1 pointer
    logic [1:0]  arb_gnt;
    logic        arb_en;

    // Grants are only taken in IDLE and never while a flush is pending
    assign arb_en = (state == IDLE) && !flush_i;

    mms_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({dtlb_req_i, itlb_req_i}),
        .en    (arb_en),
        .gnt   (arb_gnt)
    );

    assign itlb_ready_o = arb_en && arb_gnt[0];
    assign dtlb_ready_o = arb_en && arb_gnt[1];
    assign mem_req_o    = (state == L1_REQ) || (state == L0_REQ);
    // A flush landing in DONE cancels the result
    assign resp_valid_o = (state == DONE) && !flush_i;
    assign state_o      = state;

    always_comb begin
        mem_addr_o = '0;
        if (state == L1_REQ) begin
            mem_addr_o = {satp_ppn_i, req_q.vpn.vpn1, 2'b00};
        end else if (state == L0_REQ) begin
            mem_addr_o = {ppn_q, req_q.vpn.vpn0, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_q        <= '0;
            ppn_q        <= '0;
            resp_id_o    <= 1'b0;
            resp_pte_o   <= '0;
            resp_super_o <= 1'b0;
            resp_fault_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && (arb_gnt != 2'b00)) begin
                        req_q.id  <= arb_gnt[1];
                        req_q.vpn <= arb_gnt[1] ? dtlb_vpn_i : itlb_vpn_i;
                        state     <= L1_REQ;
                    end
                end
                L1_REQ, L0_REQ: begin
                    // An accepted read must still be drained after a flush
                    if (flush_i) begin
                        state <= mem_gnt_i ? DRAIN : IDLE;
                    end else if (mem_gnt_i) begin
                        state <= (state == L1_REQ) ? L1_WAIT : L0_WAIT;
                    end
                end
                L1_WAIT, L0_WAIT: begin
                    if (flush_i) begin
                        // Data returning in the flush cycle is simply dropped
                        state <= mem_rvalid_i ? IDLE : DRAIN;
                    end else if (mem_rvalid_i) begin
                        resp_id_o  <= req_q.id;
                        resp_pte_o <= mem_rdata_i;
                        ppn_q      <= {mem_rdata_i.ppn1, mem_rdata_i.ppn0};
                        if (state == L1_WAIT) begin
                            if (pte_invalid(mem_rdata_i)) begin
                                resp_fault_o <= 1'b1;
                                resp_super_o <= 1'b0;
                                state        <= DONE;
                            end else if (pte_is_leaf(mem_rdata_i)) begin
                                // Superpage must be 4 MiB aligned
                                resp_fault_o <= (mem_rdata_i.ppn0 != 10'd0);
                                resp_super_o <= (mem_rdata_i.ppn0 == 10'd0);
                                state        <= DONE;
                            end else begin
                                state <= L0_REQ;
                            end
                        end else begin
                            // A pointer at the last level is also a fault
                            resp_fault_o <= pte_invalid(mem_rdata_i) ||
                                            !pte_is_leaf(mem_rdata_i);
                            resp_super_o <= 1'b0;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (mem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mms_ptw.sv
// -----------------------------------------------------------------------------
// tb_mms_ptw
//   Bench for the Sv32 page-table walker: a PTE memory responder with
//   programmable grant/return delays, TLB request drivers, a response
//   scoreboard fed from a reference walk over the same PTE table, and one
//   task per scenario.
// -----------------------------------------------------------------------------
module tb_mms_ptw;
  import mms_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [21:0] satp_ppn_i;
  logic        flush_i;
  logic        itlb_req_i, dtlb_req_i;
  logic [19:0] itlb_vpn_i, dtlb_vpn_i;
  logic        itlb_ready_o, dtlb_ready_o;
  logic        mem_req_o;
  logic [33:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o, resp_id_o, resp_super_o, resp_fault_o;
  logic [31:0] resp_pte_o;
  ptw_state_e  state_o;

  mms_ptw dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .satp_ppn_i   (satp_ppn_i),
    .flush_i      (flush_i),
    .itlb_req_i   (itlb_req_i),
    .itlb_vpn_i   (itlb_vpn_i),
    .itlb_ready_o (itlb_ready_o),
    .dtlb_req_i   (dtlb_req_i),
    .dtlb_vpn_i   (dtlb_vpn_i),
    .dtlb_ready_o (dtlb_ready_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_id_o    (resp_id_o),
    .resp_pte_o   (resp_pte_o),
    .resp_super_o (resp_super_o),
    .resp_fault_o (resp_fault_o),
    .state_o      (state_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  // {id, super, fault, pte (0 when fault)}
  logic [34:0] exp_q[$];
  logic [31:0] mem[logic [33:0]];
  logic [33:0] addr_log[$];
  int gnt_delay = 0;
  int rvalid_delay = 0;
  int resp_seen = 0;
  int fault_seen = 0;
  logic last_id, last_super, last_fault;
  logic [31:0] last_pte;

  function automatic logic [31:0] rd_mem(logic [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference two-level Sv32 walk over the bench PTE table
  function automatic logic [34:0] model_walk(logic id, logic [19:0] vpn);
    logic [31:0] p;
    logic [31:0] q;
    p = rd_mem({satp_ppn_i, vpn[19:10], 2'b00});
    if (!p[0] || (!p[1] && p[2])) return {id, 1'b0, 1'b1, 32'h0};
    if (p[1] || p[3]) begin
      if (p[19:10] != 10'd0) return {id, 1'b0, 1'b1, 32'h0};
      return {id, 1'b1, 1'b0, p};
    end
    q = rd_mem({p[31:10], vpn[9:0], 2'b00});
    if (!q[0] || (!q[1] && q[2]) || !(q[1] || q[3])) return {id, 1'b0, 1'b1, 32'h0};
    return {id, 1'b0, 1'b0, q};
  endfunction

  // ---------------- memory responder ----------------
  logic        rd_pend;
  int          rd_wait;
  int          gnt_cnt;
  logic [33:0] rd_addr;

  initial begin
    rd_pend = 1'b0; rd_wait = 0; gnt_cnt = 0; rd_addr = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = $urandom;  // garbage whenever data is not valid
      if (!rst_n) begin
        rd_pend = 1'b0;
        gnt_cnt = 0;
      end else if (rd_pend) begin
        if (rd_wait == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = rd_mem(rd_addr);
          rd_pend = 1'b0;
        end else begin
          rd_wait--;
        end
      end else if (mem_req_o) begin
        if (gnt_cnt >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          addr_log.push_back(mem_addr_o);
          rd_addr = mem_addr_o;
          rd_pend = 1'b1;
          rd_wait = rvalid_delay;
          gnt_cnt = 0;
        end else begin
          gnt_cnt++;
        end
      end else begin
        gnt_cnt = 0;
      end
    end
  end

  // ---------------- response scoreboard ----------------
  logic [34:0] sb_exp, sb_got;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && resp_valid_o) begin
        resp_seen++;
        if (resp_fault_o) fault_seen++;
        last_id = resp_id_o; last_super = resp_super_o;
        last_fault = resp_fault_o; last_pte = resp_pte_o;
        sb_got = {resp_id_o, resp_super_o, resp_fault_o, resp_fault_o ? 32'h0 : resp_pte_o};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: got id/super/fault/pte=%h, required no response", sb_got);
        end else begin
          sb_exp = exp_q.pop_front();
          if (sb_got !== sb_exp) begin
            failures++;
            $display("FAIL resp: got id/super/fault/pte=%h, required %h", sb_got, sb_exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic id, input logic [19:0] vpn, output logic ok, output int t_grant);
    ok = 1'b0;
    t_grant = 0;
    @(negedge clk);
    if (id) begin dtlb_req_i = 1'b1; dtlb_vpn_i = vpn; end
    else    begin itlb_req_i = 1'b1; itlb_vpn_i = vpn; end
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((id && dtlb_ready_o) || (!id && itlb_ready_o)) begin
        ok = 1'b1;
        t_grant = cyc;
        exp_q.push_back(model_walk(id, vpn));
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (id) dtlb_req_i = 1'b0;
    else    itlb_req_i = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #3;
      if (state_o == IDLE && exp_q.size() == 0 && !rd_pend) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (state_o !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d, required %0d", state_o, IDLE);
    end
    checks++;
    if ({itlb_ready_o, dtlb_ready_o, mem_req_o, mem_addr_o, resp_valid_o, resp_id_o,
         resp_pte_o, resp_super_o, resp_fault_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b addr=%h valid=%b pte=%h, required all 0",
               mem_req_o, mem_addr_o, resp_valid_o, resp_pte_o);
    end
  endtask

  task automatic test_walk_l0();
    logic ok, idle_ok;
    int tg, base;
    base = resp_seen;
    gnt_delay = 0; rvalid_delay = 0;
    addr_log.delete();
    send_req(1'b0, 20'h00401, ok, tg);
    wait_idle(idle_ok);
    checks++;
    if (!(ok && idle_ok)) begin
      failures++;
      $display("FAIL walk_l0_done: got grant=%b idle=%b, required 1 1", ok, idle_ok);
    end
    checks++;
    if (addr_log.size() != 2 || addr_log[0] !== 34'h0_0001_0004 || addr_log[1] !== 34'h0_0000_1004) begin
      failures++;
      $display("FAIL walk_l0_addrs: got %0d reads first=%h, required 2 reads 0001_0004 then 0000_1004",
               addr_log.size(), addr_log.size() > 0 ? addr_log[0] : 34'h0);
    end
    checks++;
    if (resp_seen != base + 1 || last_id !== 1'b0 || last_super !== 1'b0 ||
        last_fault !== 1'b0 || last_pte !== 32'h0000_20CF) begin
      failures++;
      $display("FAIL walk_l0_resp: got n=%0d id=%b super=%b fault=%b pte=%h, required n=1 id=0 super=0 fault=0 pte=000020cf",
               resp_seen - base, last_id, last_super, last_fault, last_pte);
    end
  endtask

  task automatic test_superpage();
    logic ok, idle_ok, seen;
    int tg, lat;
    gnt_delay = 0; rvalid_delay = 0;
    addr_log.delete();
    send_req(1'b1, 20'h00800, ok, tg);
    seen = 1'b0;
    lat = -1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (resp_valid_o) begin seen = 1'b1; lat = cyc - tg; break; end
    end
    checks++;
    if (!ok || !seen || lat != 3) begin
      failures++;
      $display("FAIL super_latency: got grant=%b resp=%b latency=%0d, required 1 1 3", ok, seen, lat);
    end
    wait_idle(idle_ok);
    checks++;
    if (!idle_ok || addr_log.size() != 1 || last_super !== 1'b1 || last_fault !== 1'b0) begin
      failures++;
      $display("FAIL super_resp: got idle=%b reads=%0d super=%b fault=%b, required 1 1 1 0",
               idle_ok, addr_log.size(), last_super, last_fault);
    end
  endtask

  task automatic test_back_to_back();
    logic ok, got3;
    int base, loser_bad;
    gnt_delay = 0; rvalid_delay = 0;
    base = resp_seen;
    loser_bad = 0;
    @(negedge clk);
    itlb_req_i = 1'b1; itlb_vpn_i = 20'h00401;
    dtlb_req_i = 1'b1; dtlb_vpn_i = 20'h00800;
    #1;
    checks++;
    if ({itlb_ready_o, dtlb_ready_o} !== 2'b10) begin
      failures++;
      $display("FAIL tie1_grant: got itlb/dtlb ready=%b, required 10", {itlb_ready_o, dtlb_ready_o});
    end
    if (itlb_ready_o) exp_q.push_back(model_walk(1'b0, 20'h00401));
    @(negedge clk);
    itlb_req_i = 1'b0;
    // DTLB keeps its request up while the ITLB walk runs
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (dtlb_ready_o) loser_bad++;
      if (resp_seen == base + 1) break;
    end
    itlb_req_i = 1'b1; itlb_vpn_i = 20'h00402;
    @(negedge clk);
    #1;
    checks++;
    if ({itlb_ready_o, dtlb_ready_o} !== 2'b01 || loser_bad != 0) begin
      failures++;
      $display("FAIL tie2_grant: got itlb/dtlb ready=%b early_dtlb=%0d, required 01 and 0",
               {itlb_ready_o, dtlb_ready_o}, loser_bad);
    end
    if (dtlb_ready_o) exp_q.push_back(model_walk(1'b1, 20'h00800));
    @(negedge clk);
    dtlb_req_i = 1'b0;
    got3 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (itlb_ready_o) begin
        got3 = 1'b1;
        exp_q.push_back(model_walk(1'b0, 20'h00402));
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    itlb_req_i = 1'b0;
    wait_idle(ok);
    checks++;
    if (!got3 || !ok || resp_seen != base + 3) begin
      failures++;
      $display("FAIL b2b_third: got itlb_grant=%b idle=%b responses=%0d, required 1 1 3",
               got3, ok, resp_seen - base);
    end
  endtask

  task automatic test_faults();
    logic ok, idle_ok;
    int tg, base_f, n_ok;
    logic [19:0] vpns[4];
    vpns[0] = 20'h00C00;  // L1 pte 0
    vpns[1] = 20'h01000;  // misaligned superpage
    vpns[2] = 20'h01400;  // pointer at L0
    vpns[3] = 20'h01800;  // write-only reserved encoding
    base_f = fault_seen;
    n_ok = 0;
    gnt_delay = 0; rvalid_delay = 1;
    for (int i = 0; i < 4; i++) begin
      send_req(i[0], vpns[i], ok, tg);
      wait_idle(idle_ok);
      if (ok && idle_ok) n_ok++;
    end
    checks++;
    if (n_ok != 4 || fault_seen != base_f + 4) begin
      failures++;
      $display("FAIL faults: got walks=%0d faults=%0d, required 4 4", n_ok, fault_seen - base_f);
    end
  endtask

  task automatic test_flush();
    logic ok, idle_ok;
    int tg, base;
    gnt_delay = 0; rvalid_delay = 3;
    base = resp_seen;
    // Flush while idle blocks the grant
    @(negedge clk);
    flush_i = 1'b1; itlb_req_i = 1'b1; itlb_vpn_i = 20'h00401;
    #1;
    checks++;
    if (itlb_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_grant: got ready=%b, required 0", itlb_ready_o);
    end
    @(negedge clk);
    flush_i = 1'b0; itlb_req_i = 1'b0;
    send_req(1'b1, 20'h00800, ok, tg);
    @(negedge clk);
    #1;
    checks++;
    if (!ok || state_o !== L1_WAIT) begin
      failures++;
      $display("FAIL flush_setup: got grant=%b state=%0d, required 1 %0d", ok, state_o, L1_WAIT);
    end
    flush_i = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());  // walk is aborted
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if (state_o !== DRAIN) begin
      failures++;
      $display("FAIL flush_drain: got state=%0d, required %0d", state_o, DRAIN);
    end
    wait_idle(idle_ok);
    checks++;
    if (!idle_ok || resp_seen != base) begin
      failures++;
      $display("FAIL flush_no_resp: got idle=%b responses=%0d, required 1 0", idle_ok, resp_seen - base);
    end
    rvalid_delay = 0;
    send_req(1'b0, 20'h00401, ok, tg);
    wait_idle(idle_ok);
    checks++;
    if (!ok || !idle_ok || resp_seen != base + 1 || last_pte !== 32'h0000_20CF) begin
      failures++;
      $display("FAIL flush_recover: got idle=%b responses=%0d pte=%h, required 1 1 000020cf",
               idle_ok, resp_seen - base, last_pte);
    end
  endtask

  task automatic test_stall_reset();
    logic ok, idle_ok;
    int tg, n_req, bad_addr;
    gnt_delay = 4; rvalid_delay = 5;
    n_req = 0; bad_addr = 0;
    send_req(1'b0, 20'h00401, ok, tg);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (mem_req_o) begin
        n_req++;
        if (mem_addr_o !== 34'h0_0001_0004) bad_addr++;
      end
      if (mem_gnt_i) break;
    end
    checks++;
    if (!ok || n_req != 5 || bad_addr != 0) begin
      failures++;
      $display("FAIL stall_hold: got grant=%b req_cycles=%0d addr_changes=%0d, required 1 5 0",
               ok, n_req, bad_addr);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== IDLE || {itlb_ready_o, dtlb_ready_o, mem_req_o, mem_addr_o, resp_valid_o,
        resp_id_o, resp_pte_o, resp_super_o, resp_fault_o} !== '0) begin
      failures++;
      $display("FAIL async_reset: got state=%0d req=%b addr=%h, required IDLE and all 0",
               state_o, mem_req_o, mem_addr_o);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0; rvalid_delay = 0;
    // Arbitration history is reset too: ITLB wins the first tie again
    @(negedge clk);
    itlb_req_i = 1'b1; itlb_vpn_i = 20'h00402;
    dtlb_req_i = 1'b1; dtlb_vpn_i = 20'h00800;
    #1;
    checks++;
    if ({itlb_ready_o, dtlb_ready_o} !== 2'b10) begin
      failures++;
      $display("FAIL reset_tie: got itlb/dtlb ready=%b, required 10", {itlb_ready_o, dtlb_ready_o});
    end
    if (itlb_ready_o) exp_q.push_back(model_walk(1'b0, 20'h00402));
    if (dtlb_ready_o) exp_q.push_back(model_walk(1'b1, 20'h00800));
    @(negedge clk);
    itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
    wait_idle(idle_ok);
    checks++;
    if (!idle_ok || last_pte !== 32'h0000_30C7) begin
      failures++;
      $display("FAIL reset_recover: got idle=%b pte=%h, required 1 000030c7", idle_ok, last_pte);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    flush_i = 1'b0;
    itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
    itlb_vpn_i = '0; dtlb_vpn_i = '0;
    satp_ppn_i = 22'h00010;
    mem[{22'h10, 10'd1, 2'b00}] = 32'h0000_0401;  // pointer to PPN 1
    mem[34'h0_0000_1004]        = 32'h0000_20CF;
    mem[34'h0_0000_1008]        = 32'h0000_30C7;
    mem[{22'h10, 10'd2, 2'b00}] = 32'h0000_00CF;  // aligned superpage
    mem[{22'h10, 10'd3, 2'b00}] = 32'h0000_0000;  // invalid
    mem[{22'h10, 10'd4, 2'b00}] = 32'h0000_04CF;  // superpage with ppn0=1
    mem[{22'h10, 10'd5, 2'b00}] = 32'h0000_0801;  // pointer to PPN 2
    mem[34'h0_0000_2000]        = 32'h0000_0401;  // pointer at L0
    mem[{22'h10, 10'd6, 2'b00}] = 32'h0000_0005;  // v=1 w=1 r=0
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_walk_l0();
    test_superpage();
    test_back_to_back();
    test_faults();
    test_flush();
    test_stall_reset();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
